// File: rtl/tail_light_pkg.sv
// Shared definitions for the tail-light sequencer.
//
// Contents:
//   state_t  - sequencer state encoding (IDLE, L1..L3, R1..R3, LR3)
//   MASK_*   - per-state six-bit lamp words, bit order {LC,LB,LA,RA,RB,RC}
//   lampMask - maps a state to its lamp word
package tail_light_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    LR3  = 3'd7
  } state_t;

  // Left lamps fill from the inner lamp (LA) outward.
  // Right lamps fill from the inner lamp (RA) outward.
  localparam logic [5:0] MASK_IDLE = 6'b000_000;
  localparam logic [5:0] MASK_L1   = 6'b001_000;
  localparam logic [5:0] MASK_L2   = 6'b011_000;
  localparam logic [5:0] MASK_L3   = 6'b111_000;
  localparam logic [5:0] MASK_R1   = 6'b000_100;
  localparam logic [5:0] MASK_R2   = 6'b000_110;
  localparam logic [5:0] MASK_R3   = 6'b000_111;
  localparam logic [5:0] MASK_LR3  = 6'b111_111;

  function automatic logic [5:0] lampMask(input state_t s);
    logic [5:0] m;
    m = MASK_IDLE;
    case (s)
      IDLE:    m = MASK_IDLE;
      L1:      m = MASK_L1;
      L2:      m = MASK_L2;
      L3:      m = MASK_L3;
      R1:      m = MASK_R1;
      R2:      m = MASK_R2;
      R3:      m = MASK_R3;
      LR3:     m = MASK_LR3;
      default: m = MASK_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tail_light_fsm_tick_gen.sv
// Prescaler that produces the light-step strobe.
//
// Parameters:
//   TICK_DIV - clk cycles per step (>= 2)
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset, clears the count
//   tick  - high for the one cycle in which count == TICK_DIV-1
//   count - current prescaler value, 0..TICK_DIV-1
module tick_gen #(
  parameter int TICK_DIV = 25000000,
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          tick,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q;

  // Free-running counter that wraps at TICK_DIV-1. Reset parks it at 0 so
  // the first strobe lands TICK_DIV edges after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  // Decoded from the count so that it is low whenever reset holds the count at 0.
  assign tick  = (count_q == LAST);
  assign count = count_q;

endmodule

// File: rtl/tail_light_fsm.sv
// Tail-light sequencer (Thunderbird style).
//
// A held left or right request walks the lamps 1,2,3,off; hazard, or both
// turn requests together, flashes all six lamps on/off. Requests are sampled
// only on the step strobe, so short pulses between steps are ignored.
//
// Parameters:
//   TICK_DIV - clk cycles per light step (>= 2)
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   left, right, haz  - level requests
//   LC, LB, LA        - left lamps, outer to inner
//   RA, RB, RC        - right lamps, inner to outer
//   tick              - one-cycle step strobe (debug)
//
// Build option:
//   TAIL_LIGHT_HAZARD_EN - when defined, haz forces the all-lamps flash.
//   When undefined, haz is ignored; left+right still reach LR3.
module tail_light_fsm #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic left,
  input  logic right,
  input  logic haz,
  output logic LC,
  output logic LB,
  output logic LA,
  output logic RA,
  output logic RB,
  output logic RC,
  output logic tick
);

  import tail_light_pkg::*;

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic          stepTick;
  logic [CW-1:0] stepCount;
  logic          unusedCount;
  logic          hazEff;
  state_t        state_q;
  state_t        state_d;
  logic [5:0]    lamps_q;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) uTickGen (
    .clk  (clk),
    .rst  (rst),
    .tick (stepTick),
    .count(stepCount)
  );

  // The prescaler value is only of interest on the debug side.
  assign unusedCount = ^stepCount;
  assign tick        = stepTick;

`ifdef TAIL_LIGHT_HAZARD_EN
  assign hazEff = haz;
`else
  logic unusedHaz;
  assign unusedHaz = haz;
  assign hazEff    = 1'b0;
`endif

  // Next-state selection. A turn sequence is interrupted into the flash when
  // the opposite side or hazard is requested; the last step of every
  // sequence always returns to IDLE so the lamps blank for one step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hazEff || (left && right)) state_d = LR3;
        else if (left)                 state_d = L1;
        else if (right)                state_d = R1;
        else                           state_d = IDLE;
      end
      L1:      state_d = (hazEff || right) ? LR3 : L2;
      L2:      state_d = (hazEff || right) ? LR3 : L3;
      R1:      state_d = (hazEff || left)  ? LR3 : R2;
      R2:      state_d = (hazEff || left)  ? LR3 : R3;
      L3:      state_d = IDLE;
      R3:      state_d = IDLE;
      LR3:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and lamp word advance together on the step strobe, so the lamps are
  // registered yet always match the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lamps_q <= MASK_IDLE;
    end else if (stepTick) begin
      state_q <= state_d;
      lamps_q <= lampMask(state_d);
    end
  end

  assign {LC, LB, LA, RA, RB, RC} = lamps_q;

endmodule

// File: tb/tb_tail_light_fsm.sv
// Directed testbench for tail_light_fsm with TICK_DIV = 4.
// Expected lamp words {LC,LB,LA,RA,RB,RC} are worked out by hand from the
// step timing: after reset release the prescaler shows 3 (tick high) after
// three edges and the state moves on the fourth edge.
module tb_tail_light_fsm;

  logic clk;
  logic rst;
  logic left;
  logic right;
  logic haz;
  logic LC, LB, LA, RA, RB, RC;
  logic tick;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

`ifdef TAIL_LIGHT_HAZARD_EN
  localparam bit HAZ_ON = 1'b1;
`else
  localparam bit HAZ_ON = 1'b0;
`endif

  tail_light_fsm #(
    .TICK_DIV(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .left (left),
    .right(right),
    .haz  (haz),
    .LC   (LC),
    .LB   (LB),
    .LA   (LA),
    .RA   (RA),
    .RB   (RB),
    .RC   (RC),
    .tick (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the three request levels.
  task automatic applyStimulus(input logic l, input logic r, input logic h);
    left  = l;
    right = r;
    haz   = h;
  endtask

  // Compare the lamp word and the strobe against hand-computed values.
  task automatic checkOutput(input string tag, input logic [5:0] expLamps,
                             input logic expTick);
    logic [5:0] obsLamps;
    obsLamps = {LC, LB, LA, RA, RB, RC};
    checkCount++;
    assert (obsLamps === expLamps) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s lamps observed=%b expected=%b", tag, obsLamps, expLamps);
    end
    checkCount++;
    assert (tick === expTick) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s tick observed=%b expected=%b", tag, tick, expTick);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset over one rising edge and release it on a falling edge.
  task automatic applyReset();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("resetHeld", 6'b000000, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Held left from reset release: 1,2,3,off,1 with a step every 4 clocks.
    $display("[TB] left sequence");
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyReset();
    stepEdges(3); checkOutput("leftFirstTick", 6'b000000, 1'b1);
    stepEdges(1); checkOutput("leftL1",   6'b001000, 1'b0);
    stepEdges(4); checkOutput("leftL2",   6'b011000, 1'b0);
    stepEdges(4); checkOutput("leftL3",   6'b111000, 1'b0);
    stepEdges(4); checkOutput("leftOff",  6'b000000, 1'b0);
    stepEdges(4); checkOutput("leftL1b",  6'b001000, 1'b0);

    // Asynchronous reset in L3, between clock edges.
    $display("[TB] async reset in L3");
    stepEdges(4); checkOutput("preRstL2", 6'b011000, 1'b0);
    stepEdges(4); checkOutput("preRstL3", 6'b111000, 1'b0);
    #2 rst = 1'b1;
    #1 checkOutput("asyncRst", 6'b000000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    stepEdges(3); checkOutput("postRstTick", 6'b000000, 1'b1);
    stepEdges(1); checkOutput("postRstL1",   6'b001000, 1'b0);

    // Right sequence interrupted by hazard in R2.
    $display("[TB] right then hazard");
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyReset();
    stepEdges(4); checkOutput("rightR1", 6'b000100, 1'b0);
    stepEdges(4); checkOutput("rightR2", 6'b000110, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepEdges(4); checkOutput("hazFromR2", HAZ_ON ? 6'b111111 : 6'b000111, 1'b0);
    stepEdges(4); checkOutput("hazBlank",  6'b000000, 1'b0);

    // Left and right together flash all lamps every other step.
    $display("[TB] left and right together");
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyReset();
    stepEdges(4); checkOutput("bothOn1",  6'b111111, 1'b0);
    stepEdges(4); checkOutput("bothOff1", 6'b000000, 1'b0);
    stepEdges(4); checkOutput("bothOn2",  6'b111111, 1'b0);
    stepEdges(4); checkOutput("bothOff2", 6'b000000, 1'b0);

    // Two-cycle left pulse entirely between strobes is never sampled.
    $display("[TB] short pulse");
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepEdges(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepEdges(1); checkOutput("pulseAtTick", 6'b000000, 1'b1);
    stepEdges(1); checkOutput("pulseIgnored", 6'b000000, 1'b0);
    stepEdges(4); checkOutput("pulseStill",   6'b000000, 1'b0);

    // Hazard alone, then hazard with left.
    $display("[TB] hazard input");
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyReset();
    stepEdges(4); checkOutput("hazAlone1", HAZ_ON ? 6'b111111 : 6'b000000, 1'b0);
    stepEdges(4); checkOutput("hazAlone2", 6'b000000, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepEdges(4); checkOutput("hazLeft1", HAZ_ON ? 6'b111111 : 6'b001000, 1'b0);
    stepEdges(4); checkOutput("hazLeft2", HAZ_ON ? 6'b000000 : 6'b011000, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tail_light_fsm.md
TAIL_LIGHT_FSM -- requirements
Module: tail_light_fsm

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, meaning the number of clk cycles per light-step (0.25 s at 100 MHz); legal range >= 2.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port left  input  1  left-turn request, level.
REQ-005 SHALL have port right  input  1  right-turn request, level.
REQ-006 SHALL have port haz  input  1  hazard request, level.
REQ-007 SHALL have ports LC, LB, LA  output  1 each  left lamps, outer to inner, 1 = lit.
REQ-008 SHALL have ports RA, RB, RC  output  1 each  right lamps, inner to outer, 1 = lit.
REQ-009 SHALL have port tick  output  1  one-cycle step strobe, for debug.

Function
REQ-010 SHALL contain a prescaler counting 0..TICK_DIV-1 and wrapping to 0, with tick=1 exactly in the cycle where count==TICK_DIV-1.
REQ-011 SHALL implement states IDLE, L1, L2, L3, R1, R2, R3, LR3, and SHALL change state only on an edge where tick=1.
REQ-012 SHALL sample left/right/haz only at tick edges; pulses shorter than one tick period, falling between ticks, SHALL be ignored.
REQ-013 From IDLE the next state SHALL be: LR3 if haz or (left and right); else L1 if left; else R1 if right; else IDLE.
REQ-014 From L1 or L2 the next state SHALL be LR3 if haz or right; else the next L state (L1->L2, L2->L3).
REQ-015 From R1 or R2 the next state SHALL be LR3 if haz or left; else the next R state (R1->R2, R2->R3).
REQ-016 L3, R3 and LR3 SHALL always go to IDLE on the next tick, so that every sequence blanks for one step before restarting.
REQ-017 Lamps SHALL be registered Moore outputs that change in the same edge as the state: IDLE all off; L1 LA; L2 LA,LB; L3 LA,LB,LC; R1 RA; R2 RA,RB; R3 RA,RB,RC; LR3 all six on.
REQ-018 SHALL sequence a held left (or right) request as 1,2,3,off,1,2,3,off... with period 4*TICK_DIV clocks.
REQ-019 SHALL never light left and right lamps together except in LR3.

Reset
REQ-020 Asserting rst SHALL immediately force state IDLE, prescaler 0, tick 0 and all six lamps 0, regardless of clk.
REQ-021 After rst deasserts, the first tick SHALL occur TICK_DIV edges later; rst asserted mid-sequence SHALL abandon the sequence with no resume.

Configuration
REQ-022 Macro TAIL_LIGHT_HAZARD_EN: when defined, haz SHALL behave as in REQ-013..015.
REQ-023 When TAIL_LIGHT_HAZARD_EN is undefined, the haz port SHALL remain present but be ignored. The LR3 state SHALL remain, and left and right together SHALL still enter it.

Structure
REQ-024 A shared package tail_light_pkg SHALL hold the state enumeration and the per-state six-bit lamp masks {LC,LB,LA,RA,RB,RC}.
REQ-025 The prescaler SHALL be a sub-module tick_gen, parameterised by TICK_DIV, with outputs tick and count.

Verification (TICK_DIV=4 unless stated)
REQ-026 Hold left=1 from reset release -> lamp word {LC,LB,LA,RA,RB,RC} at successive ticks is 001000, 011000, 111000, 000000, 001000, with a step every 4 clocks.
REQ-027 Hold right=1, then assert haz in state R2 -> the next tick gives 111111 and the following tick gives 000000.
REQ-028 Assert left=1 and right=1 together from IDLE -> 111111 at the first tick, then 000000, repeating every 2 ticks.
REQ-029 Assert rst asynchronously in L3 between clock edges -> lamps read 000000 before the next clk edge; after release with left=1, 001000 appears exactly 4 edges later.
REQ-030 Apply a 2-cycle left pulse placed strictly between ticks -> state stays IDLE and the lamps stay 000000.
REQ-031 Build without TAIL_LIGHT_HAZARD_EN and hold haz=1 alone -> lamps stay 000000. Hold haz=1 with left=1 -> the normal left sequence runs.
